// File: rtl/instr_mem_loader.sv
// Encodes MIPS R/I/J field bundles into machine words and streams them into
// instruction memory, holding the core in reset until the load finishes.
module instr_mem_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [1:0]            in_fmt,
    input  logic [5:0]            in_opcode,
    input  logic [4:0]            in_rs,
    input  logic [4:0]            in_rt,
    input  logic [4:0]            in_rd,
    input  logic [4:0]            in_shamt,
    input  logic [5:0]            in_funct,
    input  logic [15:0]           in_imm,
    input  logic [25:0]           in_target,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_DONE
    } state_e;

    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e              state_q, state_d;
    logic [ADDR_WIDTH:0] wc_q, wc_d;
    logic                err_q, err_d;
    logic                last_q, last_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         data_q, data_d;

    logic [31:0]         pack_w;
    logic                legal_w;
    logic                fire_w;

    // Encoder: packed word plus opcode/format legality.
    always_comb begin
        pack_w  = '0;
        legal_w = 1'b0;
        case (in_fmt)
            2'b00: begin
                pack_w  = {in_opcode, in_rs, in_rt, in_rd,
                           in_shamt, in_funct};
                legal_w = (in_opcode == 6'b000000);
            end
            2'b01: begin
                pack_w  = {in_opcode, in_rs, in_rt, in_imm};
                legal_w = in_opcode inside {6'b001000, 6'b001100,
                                            6'b001101, 6'b001010,
                                            6'b100011, 6'b101011,
                                            6'b000100};
            end
            2'b10: begin
                pack_w  = {in_opcode, in_target};
                legal_w = (in_opcode == 6'b000010);
            end
            default: begin
                pack_w  = '0;
                legal_w = 1'b0;
            end
        endcase
    end

    assign fire_w = in_valid && (state_q == S_ACCEPT);

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        err_d   = err_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    wc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (fire_w) begin
                    if (wc_q == CAP) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (legal_w) begin
                        addr_d  = BASE_ADDR + (32'(wc_q) << 2);
                        data_d  = pack_w;
                        last_d  = in_last;
                        state_d = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                        if (in_last) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_WRITE: begin
                wc_d    = wc_q + 1'b1;
                state_d = last_q ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wc_q    <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            err_q   <= err_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign in_ready   = (state_q == S_ACCEPT);
    assign imem_we    = (state_q == S_WRITE);
    assign cpu_hold   = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign imem_addr  = addr_q;
    assign imem_wdata = data_q;
    assign error      = err_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized and directed checks of instr_mem_loader against a
// transaction-level model of the load session.
module tb_instr_mem_loader;

    localparam int          AW   = 2;
    localparam int          CAP  = 1 << AW;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct {
        logic [1:0]  fmt;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
    } bund_t;

    logic          clk = 0;
    logic          reset = 1;
    logic          start = 0;
    logic          in_valid = 0;
    logic          in_ready;
    logic          in_last = 0;
    logic [1:0]    in_fmt = 0;
    logic [5:0]    in_opcode = 0;
    logic [4:0]    in_rs = 0, in_rt = 0, in_rd = 0, in_shamt = 0;
    logic [5:0]    in_funct = 0;
    logic [15:0]   in_imm = 0;
    logic [25:0]   in_target = 0;
    logic          imem_we;
    logic [31:0]   imem_addr, imem_wdata;
    logic          cpu_hold, done, error;
    logic [AW:0]   word_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] wq[$];
    logic [63:0] eq[$];
    bund_t       sess[$];
    int          m_cnt;
    logic        m_err;
    logic [5:0]  iops[7] = '{6'h08, 6'h0C, 6'h0D, 6'h0A,
                             6'h23, 6'h2B, 6'h04};

    instr_mem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done),
        .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic legal_f(bund_t b);
        if (b.fmt == 2'b00) return b.op == 6'h00;
        if (b.fmt == 2'b01) return b.op inside {6'h08, 6'h0C, 6'h0D,
                                                6'h0A, 6'h23, 6'h2B,
                                                6'h04};
        if (b.fmt == 2'b10) return b.op == 6'h02;
        return 1'b0;
    endfunction

    function automatic logic [31:0] pack_f(bund_t b);
        if (b.fmt == 2'b00) return {b.op, b.rs, b.rt, b.rd, b.sh, b.fn};
        if (b.fmt == 2'b01) return {b.op, b.rs, b.rt, b.imm};
        return {b.op, b.tgt};
    endfunction

    function automatic bund_t mk(logic [1:0] fmt, logic [5:0] op,
                                 logic [4:0] rs, logic [4:0] rt,
                                 logic [4:0] rd, logic [5:0] fn,
                                 logic [15:0] imm, logic [25:0] tgt,
                                 logic last);
        bund_t b;
        b.fmt = fmt; b.op = op; b.rs = rs; b.rt = rt; b.rd = rd;
        b.sh = 0; b.fn = fn; b.imm = imm; b.tgt = tgt; b.last = last;
        return b;
    endfunction

    function automatic bund_t rand_b();
        bund_t b;
        b.fmt  = 2'($urandom_range(0, 3));
        b.rs   = 5'($urandom); b.rt = 5'($urandom);
        b.rd   = 5'($urandom); b.sh = 5'($urandom);
        b.fn   = 6'($urandom); b.imm = 16'($urandom);
        b.tgt  = 26'($urandom); b.op = 6'($urandom);
        b.last = 0;
        if ($urandom_range(0, 4) != 0) begin
            case (b.fmt)
                2'b00: b.op = 6'h00;
                2'b01: b.op = iops[$urandom_range(0, 6)];
                2'b10: b.op = 6'h02;
                default: ;
            endcase
        end
        return b;
    endfunction

    task automatic drive(bund_t b);
        in_fmt = b.fmt; in_opcode = b.op; in_rs = b.rs; in_rt = b.rt;
        in_rd = b.rd; in_shamt = b.sh; in_funct = b.fn;
        in_imm = b.imm; in_target = b.tgt; in_last = b.last;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_err", 32'(error), 0);
        chk("start_wc", 32'(word_count), 0);
        chk("start_hold", 32'(cpu_hold), 1);
        chk("start_done", 32'(done), 0);
    endtask

    // One handshake plus the cycle-exact checks that follow it.
    task automatic send(bund_t b, logic exp_we, logic [63:0] exp_w,
                        logic exp_err, logic exp_rdy, logic exp_done);
        int k = 0;
        @(negedge clk);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        drive(b);
        in_valid = 1;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("hs_timeout", 0, 1);
            in_valid = 0;
            return;
        end
        @(posedge clk);
        if (!exp_we) #1 in_valid = 0;
        @(negedge clk);
        in_valid = 0;
        chk("we", 32'(imem_we), 32'(exp_we));
        chk("err_n1", 32'(error), 32'(exp_err));
        if (exp_we) begin
            chk("addr", imem_addr, exp_w[63:32]);
            chk("wdata", imem_wdata, exp_w[31:0]);
            chk("ready_wr", 32'(in_ready), 0);
            @(negedge clk);
            chk("ready_n2", 32'(in_ready), 32'(!b.last));
            chk("done_n2", 32'(done), 32'(b.last));
            chk("hold_n2", 32'(cpu_hold), 32'(!b.last));
        end else begin
            chk("ready_rej", 32'(in_ready), 32'(exp_rdy));
            chk("done_rej", 32'(done), 32'(exp_done));
        end
    endtask

    // Model: walk the bundles by the session rules, send each, then
    // compare the final status and every memory write.
    task automatic run_session(string tag);
        logic [63:0] w;
        bund_t       b;
        do_start();
        wq.delete();
        eq.delete();
        m_cnt = 0;
        m_err = 0;
        for (int i = 0; i < sess.size(); i++) begin
            b = sess[i];
            if (m_cnt == CAP) begin
                m_err = 1;
                send(b, 0, 0, 1, 0, 1);
                break;
            end else if (legal_f(b)) begin
                w = {BASE + 32'(m_cnt * 4), pack_f(b)};
                eq.push_back(w);
                send(b, 1, w, m_err, 0, 0);
                m_cnt++;
                if (b.last) break;
            end else begin
                m_err = 1;
                send(b, 0, 0, 1, !b.last, b.last);
                if (b.last) break;
            end
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_hold"}, 32'(cpu_hold), 0);
        chk({tag, "_err"}, 32'(error), 32'(m_err));
        chk({tag, "_wc"}, 32'(word_count), 32'(m_cnt));
        chk({tag, "_nwr"}, 32'(wq.size()), 32'(eq.size()));
        for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
            chk({tag, "_wa"}, wq[i][63:32], eq[i][63:32]);
            chk({tag, "_wd"}, wq[i][31:0], eq[i][31:0]);
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_we"}, 32'(imem_we), 0);
        chk({tag, "_addr"}, imem_addr, BASE);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_hold"}, 32'(cpu_hold), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err"}, 32'(error), 0);
        chk({tag, "_wc"}, 32'(word_count), 0);
    endtask

    initial begin
        bund_t b;
        int    len;
        int    k;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk_reset_vals("rst");

        sess.delete();
        sess.push_back(mk(1, 6'h08, 0, 8, 0, 0, 16'd5, 0, 0));
        sess.push_back(mk(1, 6'h23, 8, 9, 0, 0, 16'd4, 0, 0));
        sess.push_back(mk(1, 6'h2B, 8, 10, 0, 0, 16'd8, 0, 1));
        run_session("t1");
        if (wq.size() >= 2) begin
            chk("t1_w0", wq[0][31:0], 32'h20080005);
            chk("t1_w1", wq[1][31:0], 32'h8D090004);
            chk("t1_a1", wq[1][63:32], 32'h4);
        end else chk("t1_count", 32'(wq.size()), 3);

        sess.delete();
        sess.push_back(mk(0, 6'h00, 8, 9, 10, 6'h20, 0, 0, 0));
        sess.push_back(mk(2, 6'h02, 0, 0, 0, 0, 0, 26'd4, 1));
        run_session("t2");
        if (wq.size() >= 2) begin
            chk("t2_w0", wq[0][31:0], 32'h01095020);
            chk("t2_w1", wq[1][31:0], 32'h08000004);
        end else chk("t2_count", 32'(wq.size()), 2);

        // Illegal R with start pulsed while in ACCEPT.
        do_start();
        wq.delete();
        send(mk(0, 6'h08, 0, 8, 0, 0, 0, 0, 0), 0, 0, 1, 1, 0);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        chk("t3_start_err", 32'(error), 1);
        chk("t3_start_rdy", 32'(in_ready), 1);
        send(mk(1, 6'h08, 0, 8, 0, 0, 16'd5, 0, 1), 1,
             {32'h0, 32'h20080005}, 1, 0, 0);
        @(negedge clk);
        chk("t3_wc", 32'(word_count), 1);
        chk("t3_nwr", 32'(wq.size()), 1);

        sess.delete();
        for (int i = 0; i < 5; i++)
            sess.push_back(mk(1, 6'h0D, 5'(i), 1, 0, 0, 16'(i), 0,
                              i == 4));
        run_session("t4");
        chk("t4_wc", 32'(word_count), 4);
        chk("t4_err", 32'(error), 1);

        // Reset during the WRITE cycle of the second word.
        do_start();
        send(mk(1, 6'h08, 1, 2, 0, 0, 16'h10, 0, 0), 1,
             {32'h0, 32'h20220010}, 0, 0, 0);
        @(negedge clk);
        drive(mk(1, 6'h08, 3, 4, 0, 0, 16'h20, 0, 0));
        in_valid = 1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        chk("t5_we", 32'(imem_we), 1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk_reset_vals("t5");
        sess.delete();
        sess.push_back(mk(1, 6'h0C, 7, 7, 0, 0, 16'hBEEF, 0, 1));
        run_session("t5b");
        if (wq.size() >= 1) chk("t5_addr", wq[0][63:32], BASE);

        for (int s = 0; s < 40; s++) begin
            sess.delete();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                b = rand_b();
                b.last = (i == len - 1) || ($urandom_range(0, 9) == 0);
                sess.push_back(b);
            end
            run_session("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Packs decoded MIPS instruction fields into 32-bit machine words and writes them sequentially into instruction memory before the single-cycle core runs. It is the encoder counterpart of the core's opcode decoder: field bundles arrive over a valid/ready stream and leave as memory write beats. The block holds the core in reset until the load completes. It sits between the testbench/boot source and the instruction memory write port, and drives the core's hold input.

## Interface
- ADDR_WIDTH, 10: log2 of instruction memory depth in words.
- BASE_ADDR, 32'h0000_0000: byte address of the first word; must be 4-byte aligned.

- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a load session; sampled only in IDLE or DONE.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_last  in  1  bundle is the final instruction of the session.
- in_fmt  in  2  00 = R, 01 = I, 10 = J, 11 = illegal.
- in_opcode  in  6; in_rs, in_rt, in_rd, in_shamt  in  5 each; in_funct  in  6; in_imm  in  16; in_target  in  26.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  32  byte write address.
- imem_wdata  out  32  packed instruction word.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  load session finished.
- error  out  1  sticky; at least one bundle was rejected.
- word_count  out  ADDR_WIDTH+1  number of words written this session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE. Reset enters IDLE.
- IDLE or DONE with start=1: clear word_count and error, then go to ACCEPT.
- In ACCEPT, in_ready=1. It is 0 in every other state.
- Handshake is in_valid & in_ready. On a handshake the bundle is validated and packed, and the word is registered.
- Packing rules:
  - R: {opcode, rs, rt, rd, shamt, funct}
  - I: {opcode, rs, rt, imm}
  - J: {opcode, target}
- Legal combinations:
  - R requires opcode 000000.
  - I requires opcode in {001000, 001100, 001101, 001010, 100011, 101011, 000100}.
  - J requires opcode 000010.
  - in_fmt=11 is always illegal.
- Legal bundle with word_count < 2^ADDR_WIDTH: go to WRITE.
- Illegal bundle: set error, drop the bundle with no write and no increment. If in_last=1 go to DONE, otherwise stay in ACCEPT.
- Overflow: a handshake while word_count == 2^ADDR_WIDTH sets error, drops the bundle, and goes to DONE regardless of in_last.
- WRITE:
  - imem_we=1, imem_addr = BASE_ADDR + 4*word_count, imem_wdata = the packed word.
  - word_count increments at the end of the cycle.
  - Next state is DONE if the captured in_last was 1, otherwise ACCEPT.
- cpu_hold=1 in IDLE, ACCEPT and WRITE; cpu_hold=0 in DONE.
- done=1 only in DONE.
- start is ignored in ACCEPT and WRITE.
- Reset mid-session: all state is discarded immediately. Already-written memory is not rolled back.
- Address arithmetic is modulo 2^32. imem_addr holds its last value outside WRITE.

## Timing
- Reset values:
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0
  - in_ready=0, cpu_hold=1, done=0, error=0, word_count=0
- start=1 at cycle t: in_ready=1 at t+1.
- Handshake at cycle n: imem_we=1 at n+1. in_ready=1 again at n+2, or done=1 and cpu_hold=0 at n+2 if last.
- Throughput is one word per 2 cycles.
- Rejected bundle at cycle n: error=1 at n+1. in_ready stays 1 at n+1 if not last.
- in_valid may be held across the WRITE cycle; the bundle is not consumed until in_ready=1.
- Outputs are registered and decoded from state; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, start, then three I-format bundles: ADDI rs=0 rt=8 imm=5, then LW rs=8 rt=9 imm=4, then the last. Required: writes 0x20080005 @0x0, 0x8D090004 @0x4, then the third word @0x8. Then done=1, cpu_hold=0, word_count=3.
- R add (rs=8, rt=9, rd=10, funct=0x20) followed by J target=4 with last. Required: 0x01095020 @0x0, 0x08000004 @0x4, error=0.
- fmt=R with opcode 001000, not last, then a legal ADDI with last. Required: error=1, one write only, 0x20080005 @0x0, word_count=1.
- ADDR_WIDTH=2: five legal bundles, the last flagged. Required: four writes @0x0–0xC, the fifth dropped, error=1, DONE with word_count=4.
- Assert reset during WRITE of word 2. Required: next cycle IDLE, all outputs at reset values. A subsequent start reloads from BASE_ADDR.
- start pulsed during ACCEPT has no effect. start in DONE clears error and word_count and raises cpu_hold.
